weight_bank_sequencer: RTL and testbench

WEIGHT_BANK_SEQUENCER -- requirements
Module: weight_bank_sequencer

---
 rtl/weight_bank_sequencer.sv | 146 ++++++++++++++
 tb/tb_weight_bank_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_sequencer.sv
// Sequences one weight bank: host writes DEPTH words into BRAM, then streams them to the MAC.
// Define WEIGHT_SEQ_LOAD_EN to include the host load path; otherwise the bank is read-only.
module weight_bank_sequencer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD_START,
  input  logic          READ_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  output logic          W_VALID,
  output logic [DW-1:0] W_DATA,
  output logic          W_LAST,
  input  logic          W_READY,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] count;
  logic          count_step;
  logic          issue;
  logic          done_next;
  logic          out_fire;

`ifndef WEIGHT_SEQ_LOAD_EN
  logic unused_load;
  assign unused_load = ^{LOAD_START, LD_VALID, LD_DATA};
`endif

  assign out_fire = W_VALID && W_READY;
  assign BUSY     = (state != IDLE);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a read request takes priority over a load request
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (READ_START) state_next = READ;
`ifdef WEIGHT_SEQ_LOAD_EN
        else if (LOAD_START) state_next = LOAD;
`endif
      end
`ifdef WEIGHT_SEQ_LOAD_EN
      LOAD: begin
        if (LD_VALID && (count == LAST_ADDR)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      READ: begin
        if (issue && (count == LAST_ADDR)) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_fire && W_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BRAM port and handshake outputs; a read is issued only when the output slot frees up
  always_comb begin
    LD_READY   = 1'b0;
    BRAM_EN    = 1'b0;
    BRAM_WE    = 1'b0;
    BRAM_ADDR  = count;
    BRAM_DI    = '0;
    issue      = 1'b0;
    count_step = 1'b0;
    case (state)
`ifdef WEIGHT_SEQ_LOAD_EN
      LOAD: begin
        LD_READY   = 1'b1;
        BRAM_DI    = LD_DATA;
        BRAM_EN    = LD_VALID;
        BRAM_WE    = LD_VALID;
        count_step = LD_VALID;
      end
`endif
      READ: begin
        issue      = !W_VALID || W_READY;
        BRAM_EN    = issue;
        count_step = issue;
      end
      default: ;
    endcase
  end

  // Address counter, output slot and completion pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count   <= '0;
      W_VALID <= 1'b0;
      W_DATA  <= '0;
      W_LAST  <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= done_next;
      if (state == IDLE) begin
        count <= '0;
      end else if (count_step) begin
        count <= (count == LAST_ADDR) ? '0 : count + AW'(1);
      end
      // BRAM_DO settled on the negedge of the issue cycle
      if (issue) begin
        W_VALID <= 1'b1;
        W_DATA  <= BRAM_DO;
        W_LAST  <= (count == LAST_ADDR);
      end else if (out_fire) begin
        W_VALID <= 1'b0;
        W_LAST  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_bank_sequencer.sv
// Directed bench for weight_bank_sequencer with a BRAM model and a contents/stream reference model.
// Exercises the load path too when WEIGHT_SEQ_LOAD_EN is defined.
module tb_weight_bank_sequencer;

  localparam int unsigned DEPTH = 28;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;

  logic          CLK, RST;
  logic          LOAD_START, READ_START, LD_VALID, LD_READY;
  logic [DW-1:0] LD_DATA;
  logic          W_VALID, W_LAST, W_READY;
  logic [DW-1:0] W_DATA;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI, BRAM_DO;
  logic          BRAM_EN, BRAM_WE, BUSY, DONE;

  weight_bank_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .READ_START(READ_START),
    .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_LAST(W_LAST), .W_READY(W_READY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DO(BRAM_DO), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // BRAM model: synchronous write, read data refreshed on negedge when enabled for read
  logic [DW-1:0] mem [0:31];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (BRAM_EN && BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
  end
  always @(negedge CLK) if (BRAM_EN && !BRAM_WE) BRAM_DO <= mem[BRAM_ADDR];

  // Reference: what the bank must hold, and stream position bookkeeping
  logic [DW-1:0] golden [0:31];
  int  vectors = 0, errors = 0;
  int  cyc = 0;
  int  rd_idx, iss_idx, ld_idx, n_wr, n_hs;
  int  first_valid_cyc, last_hs_cyc, done_cyc;
  bit  done_due, prev_stall, ld_allowed;
  logic [DW-1:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the reference, sampled mid-cycle
  task automatic compare();
    bit done_next;
    if (RST) begin
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_wvalid", 32'(W_VALID), 0);
      chk("rst_wlast", 32'(W_LAST), 0);
      chk("rst_ldready", 32'(LD_READY), 0);
      chk("rst_en", 32'(BRAM_EN), 0);
      chk("rst_we", 32'(BRAM_WE), 0);
      chk("rst_done", 32'(DONE), 0);
      rd_idx = 0; iss_idx = 0; ld_idx = 0; done_due = 0; prev_stall = 0;
      return;
    end
    done_next = 0;
    if (BRAM_WE) begin
      chk("we_allowed", 32'(ld_allowed), 1);
      chk("wr_addr", 32'(BRAM_ADDR), 32'(ld_idx));
      chk("wr_data", 32'(BRAM_DI), 32'(golden[ld_idx]));
      n_wr++;
      ld_idx++;
      if (ld_idx == DEPTH) begin ld_idx = 0; done_next = 1; end
    end
`ifndef WEIGHT_SEQ_LOAD_EN
    chk("ldready_tied", 32'(LD_READY), 0);
    chk("di_tied", 32'(BRAM_DI), 0);
`endif
    if (!BUSY) chk("en_idle", 32'(BRAM_EN), 0);
    if (BRAM_EN && !BRAM_WE) begin
      chk("rd_addr", 32'(BRAM_ADDR), 32'(iss_idx));
      iss_idx = (iss_idx + 1) % DEPTH;
    end
    if (W_VALID) begin
      chk("w_data", 32'(W_DATA), 32'(golden[rd_idx]));
      chk("w_last", 32'(W_LAST), 32'(rd_idx == DEPTH - 1));
      if (prev_stall) chk("w_hold", 32'(W_DATA), 32'(prev_data));
      if (rd_idx == 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!W_READY) chk("en_stall", 32'(BRAM_EN), 0);
      else begin
        n_hs++;
        if (rd_idx == DEPTH - 1) begin rd_idx = 0; last_hs_cyc = cyc; done_next = 1; end
        else rd_idx++;
      end
    end
    chk("done", 32'(DONE), 32'(done_due));
    if (DONE && done_cyc < 0) done_cyc = cyc;
    done_due   = done_next;
    prev_stall = W_VALID && !W_READY;
    prev_data  = W_DATA;
  endtask

  task automatic cycle();
    @(negedge CLK);
    compare();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic arm();
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; n_hs = 0; n_wr = 0;
  endtask

  int t0, c, wi;

  initial begin
    RST = 1; LOAD_START = 0; READ_START = 0; LD_VALID = 0; LD_DATA = '0; W_READY = 0;
    pre_we = 0; pre_addr = '0; pre_data = '0; ld_allowed = 0; prev_data = '0;
    arm();
    // Preload under reset: unused addresses hold a poison value
    for (int k = 0; k < 32; k++) begin
      golden[k] = (k < DEPTH) ? DW'(k) : 16'hDEAD;
      pre_we = 1; pre_addr = AW'(k);
`ifdef WEIGHT_SEQ_LOAD_EN
      pre_data = (k < DEPTH) ? 16'hFFFF : 16'hDEAD;
`else
      pre_data = golden[k];
`endif
      cycle();
    end
    pre_we = 0;
    RST = 0;
    cycle();

`ifdef WEIGHT_SEQ_LOAD_EN
    // Full-rate load of 0..27
    arm(); ld_allowed = 1; t0 = cyc;
    LOAD_START = 1; cycle(); LOAD_START = 0;
    chk("load_ldready", 32'(LD_READY), 1);
    LD_VALID = 1;
    for (int k = 0; k < DEPTH; k++) begin LD_DATA = DW'(k); cycle(); end
    LD_VALID = 0;
    for (int i = 0; i < 5 && done_cyc < 0; i++) cycle();
    chk("load_nwr", 32'(n_wr), 28);
    chk("load_done_cyc", 32'(done_cyc - t0), 29);
    chk("load_busy_after", 32'(BUSY), 0);
    ld_allowed = 0;
`else
    // Load request without the load path: must be ignored
    LOAD_START = 1; LD_VALID = 1; LD_DATA = 16'h5555; cycle(); LOAD_START = 0;
    chk("noload_busy", 32'(BUSY), 0);
    cycle(); cycle();
    chk("noload_busy2", 32'(BUSY), 0);
    LD_VALID = 0;
`endif

    // Read with no backpressure
    arm(); W_READY = 1; t0 = cyc;
    READ_START = 1; cycle(); READ_START = 0;
    for (int i = 0; i < 60 && done_cyc < 0; i++) begin
      c = cyc - t0;
      if (c == 2) chk("nostall_first", 32'(W_DATA), 32'h0000);
      if (c == 29) begin
        chk("nostall_last", 32'(W_DATA), 32'h001B);
        chk("nostall_wlast", 32'(W_LAST), 1);
      end
      cycle();
    end
    chk("nostall_done_seen", 32'(done_cyc >= 0), 1);
    chk("nostall_first_cyc", 32'(first_valid_cyc - t0), 2);
    chk("nostall_span", 32'(last_hs_cyc - first_valid_cyc), 27);
    chk("nostall_nhs", 32'(n_hs), 28);
    chk("nostall_done_cyc", 32'(done_cyc - t0), 30);
    chk("nostall_busy_after", 32'(BUSY), 0);

    // Three-cycle stall on word 5
    arm(); t0 = cyc;
    READ_START = 1; cycle(); READ_START = 0;
    for (int i = 0; i < 80 && done_cyc < 0; i++) begin
      c = cyc - t0;
      W_READY = !(c >= 7 && c <= 9);
      if (c >= 7 && c <= 10) chk("stall_word5", 32'(W_DATA), 32'h0005);
      if (c == 11) chk("resume_word6", 32'(W_DATA), 32'h0006);
      cycle();
    end
    W_READY = 1;
    chk("stall_done_seen", 32'(done_cyc >= 0), 1);
    chk("stall_done_cyc", 32'(done_cyc - t0), 33);
    chk("stall_nhs", 32'(n_hs), 28);

    // Second pattern
    for (int k = 0; k < DEPTH; k++) golden[k] = 16'h8000 + DW'(k) * 16'h0101;
`ifdef WEIGHT_SEQ_LOAD_EN
    arm(); ld_allowed = 1; wi = 0;
    LOAD_START = 1; cycle(); LOAD_START = 0;
    for (int i = 0; i < 60 && wi < DEPTH; i++) begin
      LD_VALID = (i % 3 != 2);
      LD_DATA  = LD_VALID ? golden[wi] : 16'hBAD0;
      cycle();
      if (LD_VALID) wi++;
    end
    LD_VALID = 0;
    for (int i = 0; i < 5 && done_cyc < 0; i++) cycle();
    chk("load2_nwr", 32'(n_wr), 28);
    chk("load2_done_seen", 32'(done_cyc >= 0), 1);
    ld_allowed = 0;
`else
    for (int k = 0; k < DEPTH; k++) begin
      pre_we = 1; pre_addr = AW'(k); pre_data = golden[k]; cycle();
    end
    pre_we = 0;
    cycle();
`endif

    // Simultaneous starts: read wins, load path stays closed
    arm(); t0 = cyc;
    LD_VALID = 1; LD_DATA = 16'h7777;
    READ_START = 1; LOAD_START = 1; cycle(); READ_START = 0; LOAD_START = 0;
    chk("both_busy", 32'(BUSY), 1);
    chk("both_ldready", 32'(LD_READY), 0);
    for (int i = 0; i < 60 && done_cyc < 0; i++) begin
      c = cyc - t0;
      if (c == 2) chk("both_first", 32'(W_DATA), 32'h8000);
      if (c == 29) chk("both_last", 32'(W_DATA), 32'h9B1B);
      cycle();
    end
    LD_VALID = 0;
    chk("both_done_seen", 32'(done_cyc >= 0), 1);
    chk("both_nwr", 32'(n_wr), 0);

    // Reset while word 10 is presented
    arm(); t0 = cyc;
    READ_START = 1; cycle(); READ_START = 0;
    while (cyc - t0 < 12) cycle();
    chk("abort_word10", 32'(W_DATA), 32'h8A0A);
    RST = 1; #1;
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_wvalid", 32'(W_VALID), 0);
    chk("abort_en", 32'(BRAM_EN), 0);
    chk("abort_done", 32'(DONE), 0);
    cycle();
    RST = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("abort_no_done", 32'(done_cyc < 0), 1);
    chk("abort_idle", 32'(BUSY), 0);

    // Contents survive the abort; read again under a periodic stall pattern
    arm();
    READ_START = 1; cycle(); READ_START = 0;
    for (int i = 0; i < 90 && done_cyc < 0; i++) begin
      W_READY = (i % 4 != 1);
      cycle();
    end
    W_READY = 1;
    chk("reread_done_seen", 32'(done_cyc >= 0), 1);
    chk("reread_nhs", 32'(n_hs), 28);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
